// File: rtl/axis_width_upsizer_if.sv
// Stream bundle around the narrow-to-wide upsizer: narrow input stream,
// wide output stream with per-lane keep. The upsizer uses the slave view;
// whatever drives its input and sinks its output uses the master view.
interface axis_width_upsizer_if #(
    parameter int IN_W  = 64,
    parameter int RATIO = 8
);
    // Narrow input side
    logic [IN_W-1:0]       axis_data_i;
    logic                  axis_valid_i;
    logic                  axis_last_i;
    logic                  axis_ready_o;

    // Wide output side
    logic [IN_W*RATIO-1:0] axis_data_o;
    logic                  axis_valid_o;
    logic                  axis_last_o;
    logic [RATIO-1:0]      axis_keep_o;
    logic                  axis_ready_i;

    // Upsizer view
    modport slave (
        input  axis_data_i,
        input  axis_valid_i,
        input  axis_last_i,
        output axis_ready_o,
        output axis_data_o,
        output axis_valid_o,
        output axis_last_o,
        output axis_keep_o,
        input  axis_ready_i
    );

    // Producer / consumer view
    modport master (
        output axis_data_i,
        output axis_valid_i,
        output axis_last_i,
        input  axis_ready_o,
        input  axis_data_o,
        input  axis_valid_o,
        input  axis_last_o,
        input  axis_keep_o,
        output axis_ready_i
    );
endinterface

// File: rtl/axis_width_upsizer.sv
// Packs IN_W-bit stream words into IN_W*RATIO-bit beats. Words fill lanes
// from lane 0 upward; a beat is emitted when the top lane is filled or the
// word carries last, in which case unused upper lanes are zero with keep=0.
// A single output register feeds the downstream FIFO; the input is stalled
// only while that register holds a beat the FIFO is not taking.
module axis_width_upsizer #(
    parameter int IN_W  = 64,
    parameter int RATIO = 8
) (
    input  logic                clk,
    input  logic                rst,
    axis_width_upsizer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    // Lane counter and assembly buffer
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_data_q, asm_data_d;
    logic [RATIO-1:0] asm_keep_q, asm_keep_d;

    // Output register
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0] out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;

    // Handshake terms
    logic ready;
    logic accept;
    logic complete;
    logic consume;

    // Assembly contents with the current input word merged into lane cnt
    logic [RATIO-1:0] lane_sel;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] merged_keep;

    // The input may advance whenever the output register is empty or is
    // being drained this very cycle; this is a deliberate comb path from
    // axis_ready_i so full throughput needs no skid buffer.
    assign ready    = ~out_valid_q | bus.axis_ready_i;
    assign accept   = bus.axis_valid_i & ready;
    assign consume  = out_valid_q & bus.axis_ready_i;
    assign complete = accept & ((cnt_q == LAST_LANE) | bus.axis_last_i);

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_sel[gi] = (cnt_q == CNT_W'(gi));
            assign merged_data[gi*IN_W +: IN_W] =
                lane_sel[gi] ? bus.axis_data_i : asm_data_q[gi*IN_W +: IN_W];
            assign merged_keep[gi] = asm_keep_q[gi] | lane_sel[gi];
        end
    endgenerate

    // Next-state: assemble accepted words, hand completed beats to the
    // output register, retire the output beat when the FIFO takes it.
    always_comb begin
        cnt_d       = cnt_q;
        asm_data_d  = asm_data_q;
        asm_keep_d  = asm_keep_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            // A load in the same cycle as a consume overrides the clear,
            // so back-to-back beats keep out_valid high.
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = bus.axis_last_i;
            out_valid_d = 1'b1;
            asm_data_d  = '0;
            asm_keep_d  = '0;
            cnt_d       = '0;
        end else if (accept) begin
            asm_data_d  = merged_data;
            asm_keep_d  = merged_keep;
            cnt_d       = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any partial packet and the output beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            asm_data_q  <= '0;
            asm_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            asm_data_q  <= asm_data_d;
            asm_keep_q  <= asm_keep_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.axis_ready_o = ready;
    assign bus.axis_valid_o = out_valid_q;
    assign bus.axis_data_o  = out_data_q;
    assign bus.axis_keep_o  = out_keep_q;
    assign bus.axis_last_o  = out_last_q;
endmodule
